// File: rtl/div_rr_scheduler.sv
// rtl/div_rr_scheduler.sv - round-robin scheduler sharing one combinational divider
//
// Purpose: arbitrates NUM_REQ requesters onto a single combinational unsigned
// divider. Grants rotate round-robin. Operands are registered onto div_a/div_b
// and held for SETTLE_CYC cycles before div_result is captured. The quotient is
// returned with the owning requester id over a valid/ready response port.
// A zero divisor bypasses the divider and returns all ones with rsp_dbz set.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot or zero)
//   req_a/req_b          packed operands, lane i = [i*2*WIDTH +: 2*WIDTH]
//   div_flag/div_a/div_b divider enable and operands
//   div_result           divider output {int[WIDTH], frac[FRACTIONAL_BITS]}
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/rsp_result    owning requester and quotient
//   rsp_dbz              divide-by-zero flag
//   busy                 high whenever an operation is in flight
module div_rr_scheduler #(
  parameter int WIDTH           = 8,
  parameter int FRACTIONAL_BITS = 8,
  parameter int NUM_REQ         = 4,
  parameter int SETTLE_CYC      = 1,
  localparam int IDW            = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*2*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*2*WIDTH-1:0] req_b,
  output logic                       div_flag,
  output logic [2*WIDTH-1:0]         div_a,
  output logic [2*WIDTH-1:0]         div_b,
  input  logic [2*WIDTH-1:0]         div_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [2*WIDTH-1:0]         rsp_result,
  output logic                       rsp_dbz,
  output logic                       busy
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("div_rr_scheduler: NUM_REQ must be >= 2");
  end
  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("div_rr_scheduler: SETTLE_CYC must be >= 1");
  end
  if (FRACTIONAL_BITS < 0 || FRACTIONAL_BITS > DW) begin : g_bad_frac
    $error("div_rr_scheduler: FRACTIONAL_BITS out of range");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] last_grant;
  logic [CW-1:0]  cnt;
  logic           cnt_last;

  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic           accept;
  logic [DW-1:0]  sel_a;
  logic [DW-1:0]  sel_b;

  // Search starts just after the last winner and wraps, so every valid
  // requester is reached within NUM_REQ grants.
  always_comb begin
    int cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(cand);
      end
    end
  end

  assign accept   = rst_n && (state == IDLE) && gnt_any;
  assign sel_a    = req_a[int'(gnt_idx)*DW +: DW];
  assign sel_b    = req_b[int'(gnt_idx)*DW +: DW];
  assign cnt_last = (cnt == CW'(SETTLE_CYC - 1));

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    div_flag  = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = (sel_b == '0) ? RESP : EXEC;
      end
      EXEC: begin
        div_flag = 1'b1;
        busy     = 1'b1;
        if (cnt_last) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Divider operands are only loaded for a non-zero divisor, so a B==0
  // request never disturbs the divider inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= IDW'(NUM_REQ - 1);
      cnt        <= '0;
      div_a      <= '0;
      div_b      <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_dbz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= gnt_idx;
            rsp_id     <= gnt_idx;
            cnt        <= '0;
            if (sel_b == '0) begin
              rsp_result <= '1;
              rsp_dbz    <= 1'b1;
            end else begin
              div_a <= sel_a;
              div_b <= sel_b;
            end
          end
        end
        EXEC: begin
          cnt <= cnt + 1'b1;
          if (cnt_last) begin
            rsp_result <= div_result;
            rsp_dbz    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_rr_scheduler.sv
// tb/tb_div_rr_scheduler.sv - randomized self-checking bench for div_rr_scheduler
module tb_div_rr_scheduler;

  localparam int WIDTH  = 8;
  localparam int FRAC   = 8;
  localparam int NREQ   = 4;
  localparam int SETTLE = 1;
  localparam int DW     = 2 * WIDTH;
  localparam int IDW    = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_a;
  logic [NREQ*DW-1:0]   req_b;
  logic                 div_flag;
  logic [DW-1:0]        div_a;
  logic [DW-1:0]        div_b;
  logic [DW-1:0]        div_result;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [DW-1:0]        rsp_result;
  logic                 rsp_dbz;
  logic                 busy;

  always #5 clk = ~clk;

  div_rr_scheduler #(
    .WIDTH(WIDTH), .FRACTIONAL_BITS(FRAC), .NUM_REQ(NREQ), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .div_flag(div_flag), .div_a(div_a), .div_b(div_b), .div_result(div_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_dbz(rsp_dbz), .busy(busy)
  );

  // Unsigned fixed-point quotient (A << FRAC) / B, truncated to DW bits.
  function automatic logic [DW-1:0] quot(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] num;
    num = {{DW{1'b0}}, a} << FRAC;
    if (b == '0) return '1;
    return DW'(num / {{DW{1'b0}}, b});
  endfunction

  // Stand-in for the shared combinational divider.
  assign div_result = quot(div_a, div_b);

  int            nchk = 0;
  int            nerr = 0;
  int            cyc;
  bit            outst;
  int            due;
  int            last;
  logic [IDW-1:0] e_id;
  logic [DW-1:0]  e_res;
  logic [DW-1:0]  e_a;
  logic [DW-1:0]  e_b;
  bit            e_dbz;
  int            grant_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_valid[i]      = 1'b1;
  endtask

  // One clock cycle: compare the DUT against the reference at the negedge,
  // advance the reference, then retire the accepted request after the posedge.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    int              g;
    bit              exec_now;
    bit              resp_now;
    @(negedge clk);
    exp_rdy = '0;
    g       = -1;
    if (!outst) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (last + k) % NREQ;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    exec_now = outst && !e_dbz && (cyc < due);
    resp_now = outst && (cyc >= due);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(outst));
    chk("div_flag", 32'(div_flag), 32'(exec_now));
    if (exec_now) begin
      chk("div_a", 32'(div_a), 32'(e_a));
      chk("div_b", 32'(div_b), 32'(e_b));
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(resp_now));
    if (resp_now) begin
      chk("rsp_id", 32'(rsp_id), 32'(e_id));
      chk("rsp_result", 32'(rsp_result), 32'(e_res));
      chk("rsp_dbz", 32'(rsp_dbz), 32'(e_dbz));
      if (rsp_ready) outst = 1'b0;
    end
    if (g >= 0) begin
      outst = 1'b1;
      last  = g;
      e_id  = IDW'(g);
      e_a   = req_a[g*DW +: DW];
      e_b   = req_b[g*DW +: DW];
      e_dbz = (e_b == '0);
      e_res = e_dbz ? '1 : quot(e_a, e_b);
      due   = cyc + 1 + (e_dbz ? 0 : SETTLE);
      grant_log.push_back(g);
    end
    @(posedge clk);
    #1;
    if (g >= 0) req_valid[g] = 1'b0;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_req_ready_pre", 32'(req_ready), 32'h0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_div_flag", 32'(div_flag), 32'h0);
      chk("rst_div_a", 32'(div_a), 32'h0);
      chk("rst_div_b", 32'(div_b), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_id", 32'(rsp_id), 32'h0);
      chk("rst_rsp_result", 32'(rsp_result), 32'h0);
      chk("rst_rsp_dbz", 32'(rsp_dbz), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    outst = 1'b0;
    last  = NREQ - 1;
  endtask

  task automatic fill_all();
    for (int i = 0; i < NREQ; i++)
      if (!req_valid[i]) set_req(i, DW'($urandom), DW'($urandom_range(1, 65535)));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    cyc       = 0;
    outst     = 1'b0;
    due       = 0;
    last      = NREQ - 1;
    e_id      = '0;
    e_res     = '0;
    e_a       = '0;
    e_b       = '0;
    e_dbz     = 1'b0;
    do_reset(2);

    // 6/3 and 1/2 on single requesters
    rsp_ready = 1'b1;
    set_req(0, 16'd6, 16'd3);
    repeat (5) step();
    set_req(2, 16'd1, 16'd2);
    repeat (5) step();

    // all requesters valid continuously from reset
    fill_all();
    do_reset(1);
    grant_log.delete();
    repeat (20) begin
      fill_all();
      step();
    end
    for (int k = 0; k < 5; k++) begin
      if (k < grant_log.size()) chk($sformatf("rr_order_%0d", k), 32'(grant_log[k]), 32'(k % NREQ));
      else chk($sformatf("rr_order_%0d_missing", k), 32'h0, 32'h1);
    end
    req_valid = '0;
    repeat (5) step();

    // divide by zero
    set_req(1, 16'd100, 16'd0);
    repeat (4) step();

    // response held off for several cycles while others wait
    rsp_ready = 1'b0;
    set_req(0, 16'd200, 16'd7);
    set_req(1, 16'd50, 16'd9);
    set_req(3, 16'd3000, 16'd11);
    repeat (8) step();
    rsp_ready = 1'b1;
    repeat (10) step();
    req_valid = '0;
    repeat (4) step();

    // reset during EXEC, requester 0 wins afterwards
    fill_all();
    step();
    do_reset(1);
    grant_log.delete();
    fill_all();
    repeat (4) step();
    if (grant_log.size() > 0) chk("post_reset_first", 32'(grant_log[0]), 32'h0);
    else chk("post_reset_first_missing", 32'h0, 32'h1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0)
            set_req(i, DW'($urandom),
                    ($urandom_range(0, 7) == 0) ? DW'(0) : DW'($urandom_range(1, 65535)));
        end else if ($urandom_range(0, 31) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (n == 1500) do_reset(1);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
